// File: rtl/hazard_scoreboard.sv
// Pipeline hazard detector: load-use, branch-operand and mult/div stalls, plus a
// saturating stall-cycle counter. Stall outputs are purely combinational.
module hazard_scoreboard #(
    parameter int AW     = 5,
    parameter int MD_LAT = 8,
    parameter int LW     = 4,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rtD,
    input  logic          usersD,
    input  logic          usertD,
    input  logic          branchD,
    input  logic          mdstartD,
    input  logic          mdreadD,
    input  logic [AW-1:0] writeregE,
    input  logic [AW-1:0] writeregM,
    input  logic          regwriteE,
    input  logic          memtoregE,
    input  logic          memtoregM,
    input  logic          stallclr,
    output logic          stallF,
    output logic          stallD,
    output logic          flushE,
    output logic          mdbusy,
    output logic          mddone,
    output logic [CW-1:0] stallcnt
);

    // state | meaning
    // IDLE  | mult/div unit free; a start may be accepted
    // BUSY  | operation in flight; countdown == 0 marks the result cycle
    typedef enum logic {IDLE, BUSY} md_state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    md_state_t     state_q, state_d;
    logic [LW-1:0] count_q, count_d;
    logic          lwstall, brstall, mdstall, stall;

    function automatic logic srcmatch(input logic use_bit,
                                      input logic [AW-1:0] r,
                                      input logic [AW-1:0] w);
        return use_bit && (r == w) && (w != '0);
    endfunction

    assign lwstall = regwriteE && memtoregE &&
                     (srcmatch(usersD, rsD, writeregE) || srcmatch(usertD, rtD, writeregE));
    assign brstall = branchD &&
                     ((regwriteE && (srcmatch(usersD, rsD, writeregE) ||
                                     srcmatch(usertD, rtD, writeregE))) ||
                      (memtoregM && (srcmatch(usersD, rsD, writeregM) ||
                                     srcmatch(usertD, rtD, writeregM))));
    // mdbusy covers the mddone cycle too, so a start/read then still waits a cycle
    assign mdbusy  = (state_q == BUSY);
    assign mdstall = (mdstartD || mdreadD) && mdbusy;
    assign stall   = lwstall || brstall || mdstall;

    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mddone  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdstartD && !stall) begin
                    state_d = BUSY;
                    count_d = LW'(MD_LAT - 1);
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    mddone  = 1'b1;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallcnt <= '0;
        end else if (stallclr) begin
            stallcnt <= '0;
        end else if (stall && (stallcnt != CNT_MAX)) begin
            stallcnt <= stallcnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios then random traffic,
// expectations from a cycle-level reference model, checked by a decoupled monitor.
module tb_hazard_scoreboard;

    localparam int AW     = 5;
    localparam int MD_LAT = 4;
    localparam int LW     = 4;
    localparam int CW     = 3;
    localparam int CMAX   = (1 << CW) - 1;

    typedef struct {
        logic          rst_n;
        logic [AW-1:0] rs, rt, we, wm;
        logic          us, ut, br, mds, mdr, rwe, mte, mtm, clr;
    } stim_t;

    typedef struct {
        logic          stall, busy, done;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] rsD, rtD, writeregE, writeregM;
    logic          usersD, usertD, branchD, mdstartD, mdreadD;
    logic          regwriteE, memtoregE, memtoregM, stallclr;
    logic          stallF, stallD, flushE, mdbusy, mddone;
    logic [CW-1:0] stallcnt;

    hazard_scoreboard #(.AW(AW), .MD_LAT(MD_LAT), .LW(LW), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .rsD(rsD), .rtD(rtD), .usersD(usersD), .usertD(usertD),
        .branchD(branchD), .mdstartD(mdstartD), .mdreadD(mdreadD),
        .writeregE(writeregE), .writeregM(writeregM),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .memtoregM(memtoregM),
        .stallclr(stallclr),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .mdbusy(mdbusy), .mddone(mddone), .stallcnt(stallcnt)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: remaining mult/div cycles and stall count as plain integers.
    int md_rem = 0;
    int cnt_m  = 0;

    function automatic logic hit(input logic u, input logic [AW-1:0] r, input logic [AW-1:0] w);
        return u && (r == w) && (w != 0);
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst_n = 1'b1;
        s.rs = '0; s.rt = '0; s.we = '0; s.wm = '0;
        s.us = 0; s.ut = 0; s.br = 0; s.mds = 0; s.mdr = 0;
        s.rwe = 0; s.mte = 0; s.mtm = 0; s.clr = 0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        logic lw, brs, opE, opM;
        @(negedge clk);
        reset_n = s.rst_n; rsD = s.rs; rtD = s.rt; writeregE = s.we; writeregM = s.wm;
        usersD = s.us; usertD = s.ut; branchD = s.br; mdstartD = s.mds; mdreadD = s.mdr;
        regwriteE = s.rwe; memtoregE = s.mte; memtoregM = s.mtm; stallclr = s.clr;
        #1;
        if (!s.rst_n) begin
            md_rem = 0;
            cnt_m  = 0;
        end
        opE    = hit(s.us, s.rs, s.we) || hit(s.ut, s.rt, s.we);
        opM    = hit(s.us, s.rs, s.wm) || hit(s.ut, s.rt, s.wm);
        lw     = s.rwe && s.mte && opE;
        brs    = s.br && ((s.rwe && opE) || (s.mtm && opM));
        e.busy = (md_rem > 0);
        e.done = (md_rem == 1);
        e.stall = lw || brs || ((s.mds || s.mdr) && e.busy);
        e.cnt  = CW'(cnt_m);
        exp_q.push_back(e);
        if (s.rst_n) begin
            if (md_rem > 0) md_rem--;
            else if (s.mds && !e.stall) md_rem = MD_LAT;
            if (s.clr) cnt_m = 0;
            else if (e.stall && cnt_m < CMAX) cnt_m++;
        end
    endtask

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set just before the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                chk("stallF",   CW'(stallF), CW'(e.stall));
                chk("stallD",   CW'(stallD), CW'(e.stall));
                chk("flushE",   CW'(flushE), CW'(e.stall));
                chk("mdbusy",   CW'(mdbusy), CW'(e.busy));
                chk("mddone",   CW'(mddone), CW'(e.done));
                chk("stallcnt", stallcnt,    e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        reset_n = 1'b0;
        {rsD, rtD, writeregE, writeregM} = '0;
        {usersD, usertD, branchD, mdstartD, mdreadD} = '0;
        {regwriteE, memtoregE, memtoregM, stallclr} = '0;

        s = idle_stim(); s.rst_n = 0;
        repeat (2) drive(s);
        // stall outputs stay live during reset
        s.rwe = 1; s.mte = 1; s.we = 5'd3; s.rs = 5'd3; s.us = 1;
        drive(s);

        s = idle_stim();
        drive(s);
        s.rwe = 1; s.mte = 1; s.we = 5'd8; s.rs = 5'd8; s.us = 1;
        drive(s);
        s.us = 0;
        drive(s);

        s = idle_stim();
        s.rwe = 1; s.mte = 1; s.we = 5'd0; s.rs = 5'd0; s.rt = 5'd0; s.us = 1; s.ut = 1;
        drive(s);

        s = idle_stim(); s.clr = 1;
        drive(s);
        s = idle_stim(); s.br = 1; s.mtm = 1; s.wm = 5'd5; s.rt = 5'd5; s.ut = 1;
        drive(s);
        s = idle_stim();
        drive(s);

        s = idle_stim(); s.mds = 1;
        drive(s);
        s = idle_stim(); s.mdr = 1;
        repeat (6) drive(s);
        s = idle_stim();
        drive(s);

        s = idle_stim(); s.rwe = 1; s.mte = 1; s.we = 5'd9; s.rt = 5'd9; s.ut = 1;
        repeat (10) drive(s);
        s.clr = 1;
        drive(s);
        s = idle_stim();
        drive(s);

        s = idle_stim(); s.mds = 1;
        drive(s);
        s = idle_stim();
        drive(s);
        s.rst_n = 0;
        drive(s);
        s = idle_stim();
        repeat (6) drive(s);

        for (int i = 0; i < 600; i++) begin
            s.rst_n = ($urandom_range(0, 79) != 0);
            s.rs  = AW'($urandom_range(0, 3));
            s.rt  = AW'($urandom_range(0, 3));
            s.we  = AW'($urandom_range(0, 3));
            s.wm  = AW'($urandom_range(0, 3));
            s.us  = 1'($urandom);
            s.ut  = 1'($urandom);
            s.br  = ($urandom_range(0, 3) == 0);
            s.mds = ($urandom_range(0, 5) == 0);
            s.mdr = ($urandom_range(0, 5) == 0);
            s.rwe = 1'($urandom);
            s.mte = ($urandom_range(0, 2) == 0);
            s.mtm = ($urandom_range(0, 2) == 0);
            s.clr = ($urandom_range(0, 15) == 0);
            drive(s);
        end

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        #6;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected outputs never checked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter AW, default 5; register-address width, register file holds 2^AW entries.
REQ-002 Parameter MD_LAT, default 8; multiply/divide latency in cycles, range 1..2^LW-1.
REQ-003 Parameter LW, default 4; multiply/divide countdown width.
REQ-004 Parameter CW, default 16; stall-counter width.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 Port: clk  in  1  rising-edge clock.
REQ-007 Port: reset_n  in  1  asynchronous active-low reset.
REQ-008 Port: rsD, rtD  in  AW each  decode-stage source registers.
REQ-009 Port: usersD, usertD  in  1 each  decode instruction actually reads rs / rt.
REQ-010 Port: branchD  in  1  decode instruction is a branch resolved in D.
REQ-011 Port: mdstartD  in  1  decode instruction starts a mult/div.
REQ-012 Port: mdreadD  in  1  decode instruction reads HI/LO (mfhi/mflo).
REQ-013 Port: writeregE, writeregM  in  AW each  destination registers in E / M.
REQ-014 Port: regwriteE, memtoregE, memtoregM  in  1 each  E/M control bits.
REQ-015 Port: stallclr  in  1  synchronous clear of the stall counter.
REQ-016 Port: stallF, stallD, flushE  out  1 each  pipeline control.
REQ-017 Port: mdbusy  out  1  mult/div unit occupied.
REQ-018 Port: mddone  out  1  one-cycle pulse when the HI/LO result is ready.
REQ-019 Port: stallcnt  out  CW  saturating count of stalled cycles.

Function
REQ-020 Operand match: srcmatch(r, w) = use bit & (r == w) & (w != 0); register 0 never causes a hazard.
REQ-021 lwstall = regwriteE & memtoregE & (srcmatch(rsD, writeregE) | srcmatch(rtD, writeregE)).
REQ-022 brstall = branchD & ((regwriteE & match against writeregE) | (memtoregM & match against writeregM)), using REQ-020 matching.
REQ-023 mdstall = (mdstartD | mdreadD) & mdbusy.
REQ-024 stallD = stallF = flushE = lwstall | brstall | mdstall; combinational, same cycle as inputs.
REQ-025 Mult/div FSM states: IDLE, BUSY; mdbusy = (state == BUSY).
REQ-026 IDLE -> BUSY when mdstartD & ~stallD; countdown loads MD_LAT-1.
REQ-027 BUSY with countdown != 0: decrement by 1 per cycle.
REQ-028 BUSY with countdown == 0: mddone = 1 this cycle; next state IDLE.
REQ-029 A start or HI/LO read issued during the mddone cycle stays stalled; it proceeds in the following (IDLE) cycle.
REQ-030 MD_LAT = 1: BUSY lasts exactly one cycle, and mddone is asserted in that cycle.
REQ-031 mdstartD with stallD = 1 from lwstall or brstall: not accepted; FSM stays IDLE.
REQ-032 stallcnt increments by 1 on each clock edge where stallD = 1, and saturates at 2^CW-1 (no wrap).
REQ-033 stallclr = 1 sets stallcnt to 0 on the next edge; it has priority over a simultaneous increment.
REQ-034 mddone and stall outputs have no internal latency beyond REQ-024 and REQ-028; no other outputs are registered except state, countdown and stallcnt.

Reset
REQ-035 When reset_n = 0, regardless of clk: state = IDLE, countdown = 0, stallcnt = 0, mdbusy = 0, mddone = 0.
REQ-036 Stall outputs remain combinational during reset; with the FSM in IDLE they reflect only lwstall | brstall.
REQ-037 Reset asserted while BUSY aborts the operation; no mddone pulse follows reset release.

Verification
REQ-038 lw to r8 in E (regwriteE = 1, memtoregE = 1, writeregE = 8), rsD = 8, usersD = 1 -> stallF = stallD = flushE = 1; repeat with usersD = 0 -> all 0.
REQ-039 writeregE = 0 with a load in E, rsD = rtD = 0, both use bits set -> no stall.
REQ-040 branchD = 1, memtoregM = 1, writeregM = 5, rtD = 5, usertD = 1 -> stall 1 cycle; stallcnt goes 0 -> 1.
REQ-041 MD_LAT = 4, mdstartD pulsed in IDLE -> mdbusy high 4 cycles, mddone on the 4th; mdreadD held from the next cycle -> stall 4 cycles, released in the cycle after mddone.
REQ-042 CW = 3, stall held 10 cycles -> stallcnt saturates at 7; stallclr together with stall -> stallcnt = 0.
REQ-043 reset_n low mid-BUSY (countdown = 2) -> mdbusy = 0 immediately; after release, no mddone and the FSM is IDLE.
